// File: rtl/dm_pkg.sv
// dm_pkg: shared FSM states, write-strobe constant and bus request payload
// for the data-memory access controller.
package dm_pkg;
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} dm_state_e;
    localparam logic [3:0] DM_WSTRB_NONE = 4'hf;
    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } dm_req_t;
endpackage

// File: rtl/dm_wbuf.sv
// dm_wbuf: single-entry posted-write buffer; owns the data bus from push
// until the matching write response returns.
module dm_wbuf
    import dm_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  dm_req_t push_req,
    input  logic    req_ready,
    input  logic    resp_valid,
    output logic    busy,
    output logic    req_valid,
    output dm_req_t req
);
    logic sent;
    assign req_valid = busy && !sent;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            busy <= 1'b0;
            sent <= 1'b0;
            req  <= '0;
        end else if (!busy) begin
            if (push) begin
                busy <= 1'b1;
                req  <= push_req;
            end
        end else if (!sent)
            sent <= req_ready;
        else if (resp_valid) begin
            busy <= 1'b0;
            sent <= 1'b0;
        end
endmodule

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: MEM-stage data-memory access FSM with valid/ready bus.
// Define DM_WRITE_BUFFER_EN to post stores through a single-entry buffer.
module dm_access_ctrl
    import dm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_MemRead,
    input  logic [3:0]  MEM_MemWrite,
    input  logic [31:0] MEM_ALU_out,
    input  logic [31:0] MEM_Forward_rs2_data,
    input  logic        IM_stall,
    output logic        DM_stall,
    output logic [31:0] DM_rdata,
    output logic        dm_req_valid,
    input  logic        dm_req_ready,
    output logic        dm_req_write,
    output logic [31:0] dm_req_addr,
    output logic [31:0] dm_req_wdata,
    output logic [3:0]  dm_req_wstrb,
    input  logic        dm_resp_valid,
    input  logic [31:0] dm_resp_rdata
);
    dm_state_e state;
    dm_req_t   cur, held, ctl_req, bus_req;
    logic      is_wr, access, issue, park, idle_stall, ctl_valid;
    assign is_wr   = MEM_MemWrite != DM_WSTRB_NONE;
    assign access  = MEM_MemRead || is_wr;
    assign cur     = '{write: is_wr, addr: MEM_ALU_out, wdata: MEM_Forward_rs2_data, wstrb: ~MEM_MemWrite};
    assign ctl_req = state == REQ ? held : cur;
    assign ctl_valid = issue || state == REQ;
`ifdef DM_WRITE_BUFFER_EN
    logic    wb_busy, wb_valid, post;
    dm_req_t wb_req;
    dm_wbuf u_wbuf (
        .clk        (clk),
        .rst        (rst),
        .push       (post),
        .push_req   (cur),
        .req_ready  (dm_req_ready),
        .resp_valid (dm_resp_valid),
        .busy       (wb_busy),
        .req_valid  (wb_valid),
        .req        (wb_req)
    );
    // Stores bypass the FSM; a stalled fetch parks in DONE so the same store is not posted twice.
    assign post         = state == IDLE && is_wr && !wb_busy;
    assign issue        = state == IDLE && MEM_MemRead && !is_wr && !wb_busy;
    assign park         = post && IM_stall;
    assign idle_stall   = access && !post;
    assign dm_req_valid = wb_busy ? wb_valid : ctl_valid;
    assign bus_req      = wb_busy ? wb_req : ctl_req;
`else
    assign issue        = state == IDLE && access;
    assign park         = 1'b0;
    assign idle_stall   = access;
    assign dm_req_valid = ctl_valid;
    assign bus_req      = ctl_req;
`endif
    assign {dm_req_write, dm_req_addr, dm_req_wdata, dm_req_wstrb} = bus_req;
    assign DM_stall = state == REQ || state == RESP || (state == IDLE && idle_stall);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= IDLE;
            held     <= '0;
            DM_rdata <= '0;
        end else
            case (state)
                IDLE: if (issue) begin
                    held  <= cur;
                    state <= dm_req_ready ? RESP : REQ;
                end else if (park)
                    state <= DONE;
                REQ:  if (dm_req_ready) state <= RESP;
                RESP: if (dm_resp_valid) begin
                    if (!held.write) DM_rdata <= dm_resp_rdata;
                    state <= DONE;
                end
                DONE: if (!IM_stall) state <= IDLE;
                default: state <= IDLE;
            endcase
endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: directed and randomized program-order checks of
// dm_access_ctrl against a bus responder and a program-order memory model.
module tb_dm_access_ctrl;
    import dm_pkg::*;
    typedef struct packed {
        logic        rd;
        logic [3:0]  we_n;
        logic [31:0] addr;
        logic [31:0] wdata;
    } inst_t;
    logic        clk = 1'b0, rst = 1'b1;
    logic        MEM_MemRead = 1'b0, IM_stall = 1'b0, DM_stall;
    logic [3:0]  MEM_MemWrite = 4'hf;
    logic [31:0] MEM_ALU_out = '0, MEM_Forward_rs2_data = '0, DM_rdata;
    logic        dm_req_valid, dm_req_ready = 1'b0, dm_req_write;
    logic [31:0] dm_req_addr, dm_req_wdata;
    logic [3:0]  dm_req_wstrb;
    logic        dm_resp_valid = 1'b0;
    logic [31:0] dm_resp_rdata = '0;
    int n_vec = 0, n_err = 0;
    inst_t   prog[$];
    dm_req_t exp_q[$];
    bit      rdy_q[$], im_q[$];
    int      stall_hist[$];
    logic [31:0] ref_mem[16], dev_mem[16];
    int pc = 0, rdy_pct = 100, im_pct = 0, max_dly = 0, spur_pct = 0, dly = 0;
    bit pending = 0, hold_chk = 0, no_resp = 0;
    dm_req_t pend, last_req;
    int c_stall = 0, c_free = 0, c_valid = 0, c_hs = 0, c_wait = 0;
    int l_stall, l_free, l_valid, l_hs, l_wait;

    always #5 clk = ~clk;

    dm_access_ctrl dut (
        .clk                  (clk),
        .rst                  (rst),
        .MEM_MemRead          (MEM_MemRead),
        .MEM_MemWrite         (MEM_MemWrite),
        .MEM_ALU_out          (MEM_ALU_out),
        .MEM_Forward_rs2_data (MEM_Forward_rs2_data),
        .IM_stall             (IM_stall),
        .DM_stall             (DM_stall),
        .DM_rdata             (DM_rdata),
        .dm_req_valid         (dm_req_valid),
        .dm_req_ready         (dm_req_ready),
        .dm_req_write         (dm_req_write),
        .dm_req_addr          (dm_req_addr),
        .dm_req_wdata         (dm_req_wdata),
        .dm_req_wstrb         (dm_req_wstrb),
        .dm_resp_valid        (dm_resp_valid),
        .dm_resp_rdata        (dm_resp_rdata)
    );

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_acc(inst_t i);
        return i.rd || i.we_n != 4'hf;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] strb);
        for (int b = 0; b < 4; b++) if (strb[b]) old[b*8 +: 8] = d[b*8 +: 8];
        return old;
    endfunction

    task automatic add(input bit rd, input logic [3:0] we_n, input int idx, input logic [31:0] wdata);
        inst_t i;
        dm_req_t e;
        i = '{rd, we_n, 32'h100 + 32'(idx * 4), wdata};
        prog.push_back(i);
        e = '{we_n != 4'hf, i.addr, wdata, ~we_n};
        if (is_acc(i)) exp_q.push_back(e);
    endtask

    task automatic tick();
        inst_t   i;
        dm_req_t e, seen;
        bit      hs, retire;
        @(negedge clk);
        if (pc < prog.size()) i = prog[pc];
        else i = '{1'b0, 4'hf, $urandom, $urandom};
        MEM_MemRead = i.rd;
        MEM_MemWrite = i.we_n;
        MEM_ALU_out = i.addr;
        MEM_Forward_rs2_data = i.wdata;
        IM_stall = im_q.size() > 0 ? im_q.pop_front() : ($urandom_range(99) < im_pct);
        dm_req_ready = rdy_q.size() > 0 ? rdy_q.pop_front() : ($urandom_range(99) < rdy_pct);
        dm_resp_valid = no_resp ? 1'b0 : pending ? (dly == 0) : ($urandom_range(99) < spur_pct);
        dm_resp_rdata = (pending && !pend.write) ? dev_mem[pend.addr[5:2]] : $urandom;
        #1;
        seen = '{dm_req_write, dm_req_addr, dm_req_wdata, dm_req_wstrb};
        if (hold_chk) begin
            check("req_hold_valid", dm_req_valid, 1);
            check("req_hold_payload", seen, last_req);
        end
        hs = dm_req_valid && dm_req_ready;
        if (hs) begin
            check("no_overlap", pending, 0);
            check("req_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("req_write", dm_req_write, e.write);
                check("req_addr", dm_req_addr, e.addr);
                check("req_wstrb", dm_req_wstrb, e.wstrb);
                if (e.write) check("req_wdata", dm_req_wdata, e.wdata);
            end
        end
        if (is_acc(i)) begin
            c_stall += int'(DM_stall);
            c_free  += int'(!DM_stall);
            c_valid += int'(dm_req_valid);
            c_hs    += int'(hs);
            c_wait  += int'(DM_stall && !dm_req_valid);
        end else
            check("nop_stall", DM_stall, 0);
        if (i.rd && i.we_n == 4'hf && !DM_stall)
            check("ld_data", DM_rdata, ref_mem[i.addr[5:2]]);
        retire = !IM_stall && !DM_stall;
        @(posedge clk);
        if (pending && dm_resp_valid) begin
            if (pend.write) dev_mem[pend.addr[5:2]] = merge(dev_mem[pend.addr[5:2]], pend.wdata, pend.wstrb);
            pending = 0;
        end else if (pending && dly > 0)
            dly--;
        if (hs) begin
            pending = 1;
            pend = seen;
            dly = $urandom_range(max_dly);
        end
        hold_chk = dm_req_valid && !dm_req_ready;
        last_req = seen;
        if (retire && pc < prog.size()) begin
            if (i.we_n != 4'hf) ref_mem[i.addr[5:2]] = merge(ref_mem[i.addr[5:2]], i.wdata, ~i.we_n);
            pc++;
            stall_hist.push_back(c_stall);
            {l_stall, l_free, l_valid, l_hs, l_wait} = {c_stall, c_free, c_valid, c_hs, c_wait};
            {c_stall, c_free, c_valid, c_hs, c_wait} = '0;
        end
    endtask

    task automatic run_prog();
        int cyc = 0;
        while ((pc < prog.size() || exp_q.size() > 0 || pending) && cyc < 20000) begin
            tick();
            cyc++;
        end
        check("prog_done", pc, prog.size());
        check("req_all_issued", exp_q.size(), 0);
    endtask

    initial begin
        int h0, r;
        for (int k = 0; k < 16; k++) begin
            ref_mem[k] = $urandom;
            dev_mem[k] = ref_mem[k];
        end
        ref_mem[0] = 32'hDEADBEEF;
        dev_mem[0] = 32'hDEADBEEF;
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_stall", DM_stall, 0);
        check("rst_in_valid", dm_req_valid, 0);
        check("rst_in_rdata", DM_rdata, 0);
        rst = 1'b0;
        // Minimum-latency load.
        add(1, 4'hf, 0, 0);
        run_prog();
        check("ld_wait_cycles", l_wait, 1);
        check("ld_handshakes", l_hs, 1);
        check("ld_deadbeef", DM_rdata, 32'hDEADBEEF);
        // Ready held low for three cycles.
        rdy_q = '{0, 0, 0, 1};
        add(1, 4'hf, 3, 0);
        run_prog();
        check("req_valid_cycles", l_valid, 4);
        check("req_handshakes", l_hs, 1);
        check("req_stall_cycles", l_stall, 5);
        // Fetch stall keeps the load in DONE.
        im_q = '{1, 1, 1, 1, 1, 1, 1};
        add(1, 4'hf, 5, 0);
        run_prog();
        check("done_free_cycles", l_free, 6);
        check("done_handshakes", l_hs, 1);
        // Partial stores, store-with-read, then read back.
        add(0, 4'b1100, 2, 32'hCAFEF00D);
        add(1, 4'b1100, 2, 32'h12345678);
        add(1, 4'b1010, 6, 32'hA5A5A5A5);
        add(1, 4'hf, 2, 0);
        add(1, 4'hf, 6, 0);
        run_prog();
        // Reset while waiting for a response.
        no_resp = 1;
        add(1, 4'hf, 4, 0);
        tick();
        @(negedge clk);
        MEM_MemRead = 1'b0;
        MEM_MemWrite = 4'hf;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_resp_stall", DM_stall, 0);
        check("rst_resp_rdata", DM_rdata, 0);
        check("rst_resp_valid", dm_req_valid, 0);
        pending = 0;
        hold_chk = 0;
        no_resp = 0;
        pc = prog.size();
        {c_stall, c_free, c_valid, c_hs, c_wait} = '0;
`ifdef DM_WRITE_BUFFER_EN
        // Posted store followed at once by a load to the same word.
        h0 = stall_hist.size();
        add(0, 4'b0000, 7, 32'h0BADF00D);
        add(1, 4'hf, 7, 0);
        run_prog();
        check("wb_post_stall", stall_hist[h0], 0);
        check("wb_load_waited", stall_hist[h0+1] > 2, 1);
`endif
        rdy_pct = 60; im_pct = 30; max_dly = 3; spur_pct = 10;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(9);
            if (r < 4) add(1, 4'hf, $urandom_range(15), 0);
            else if (r < 8) add(0, 4'($urandom_range(14)), $urandom_range(15), $urandom);
            else if (r < 9) add(1, 4'($urandom_range(14)), $urandom_range(15), $urandom);
            else add(0, 4'hf, $urandom_range(15), $urandom);
        end
        run_prog();
        rdy_pct = 100; im_pct = 10; max_dly = 0; spur_pct = 0;
        for (int n = 0; n < 100; n++) begin
            if ($urandom_range(1) == 1) add(1, 4'hf, $urandom_range(15), 0);
            else add(0, 4'($urandom_range(14)), $urandom_range(15), $urandom);
        end
        run_prog();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
